// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and datapath defaults
package alu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_SLL = 5'd6;
  localparam logic [4:0] ALU_SRL = 5'd7;
  localparam logic [4:0] ALU_SRA = 5'd8;
  localparam logic [4:0] ALU_SLT = 5'd9;
endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result, zero and signed-overflow flag
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [4:0]        alu_ctrl,
  input  logic              sign,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf
);
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              lt;
  logic              add_ovf;
  logic              sub_ovf;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign lt   = sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

  // Signed overflow: the result sign disagrees with what the operand signs allow.
  assign add_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
  assign sub_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        result = sum;
        ovf    = sign & add_ovf;
      end
      ALU_SUB: begin
        result = diff;
        ovf    = sign & sub_ovf;
      end
      ALU_AND: result = op_a & op_b;
      ALU_OR:  result = op_a | op_b;
      ALU_XOR: result = op_a ^ op_b;
      ALU_NOR: result = ~(op_a | op_b);
      ALU_SLL: result = op_b << shamt;
      ALU_SRL: result = op_b >> shamt;
      ALU_SRA: result = $unsigned($signed(op_b) >>> shamt);
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, lt};
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage with EX/MEM register, stall/flush control
module ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        alu_ctrl,
  input  logic              sign,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [4:0]        shamt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_ovf,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write
);
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_ovf;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .alu_ctrl (alu_ctrl),
    .sign     (sign),
    .op_a     (op_a),
    .op_b     (op_b),
    .shamt    (shamt),
    .result   (alu_result),
    .zero     (alu_zero),
    .ovf      (alu_ovf)
  );

  // An invalid slot that is not stalled enters EX/MEM as a bubble, same as flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_ovf       <= 1'b0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_ovf       <= 1'b0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
    end else if (!stall) begin
      out_valid     <= 1'b1;
      out_result    <= alu_result;
      out_zero      <= alu_zero;
      out_ovf       <= alu_ovf;
      out_rd        <= in_rd;
      out_reg_write <= in_reg_write & ~alu_ovf;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage against an arithmetic reference model
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  alu_ctrl;
  logic        sign;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_ovf;
  logic [4:0]  out_rd;
  logic        out_reg_write;

  int n_assert = 0;
  int n_fail   = 0;

  logic        e_valid, e_zero, e_ovf, e_rw;
  logic [31:0] e_result;
  logic [4:0]  e_rd;

  ex_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .alu_ctrl      (alu_ctrl),
    .sign          (sign),
    .op_a          (op_a),
    .op_b          (op_b),
    .shamt         (shamt),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .stall         (stall),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_ovf       (out_ovf),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
  );

  always #5 clk = ~clk;

  // Reference ALU in plain integer arithmetic on 64-bit values.
  function automatic void ref_alu(input logic [4:0] op, input logic sg, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  output logic [31:0] r, output logic v);
    longint sa, sb, ua, ub, t, d, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    d  = longint'(1) << sh;
    r  = 32'h0;
    v  = 1'b0;
    case (op)
      5'd0: begin
        t = sg ? sa + sb : ua + ub;
        r = t[31:0];
        v = sg && (t > 64'sd2147483647 || t < -64'sd2147483648);
      end
      5'd1: begin
        t = sg ? sa - sb : ua - ub;
        r = t[31:0];
        v = sg && (t > 64'sd2147483647 || t < -64'sd2147483648);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = ~(a | b);
      5'd6: begin t = ub * d; r = t[31:0]; end
      5'd7: begin t = ub / d; r = t[31:0]; end
      5'd8: begin
        q = sb / d;
        if (sb < 0 && (sb % d) != 0) q = q - 1;
        r = q[31:0];
      end
      5'd9: r = (sg ? (sa < sb) : (ua < ub)) ? 32'd1 : 32'd0;
      default: begin r = 32'h0; v = 1'b0; end
    endcase
  endfunction

  task automatic clear_model();
    e_valid = 0; e_result = 0; e_zero = 0; e_ovf = 0; e_rd = 0; e_rw = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"},  32'(out_valid),     32'(e_valid));
    chk({tag, ".result"}, out_result,         e_result);
    chk({tag, ".zero"},   32'(out_zero),      32'(e_zero));
    chk({tag, ".ovf"},    32'(out_ovf),       32'(e_ovf));
    chk({tag, ".rd"},     32'(out_rd),        32'(e_rd));
    chk({tag, ".rw"},     32'(out_reg_write), 32'(e_rw));
  endtask

  task automatic drive(input logic [4:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] rd, input logic rw, input logic vld,
                       input logic stl, input logic fl);
    alu_ctrl = op; sign = sg; op_a = a; op_b = b; shamt = sh;
    in_rd = rd; in_reg_write = rw; in_valid = vld; stall = stl; flush = fl;
  endtask

  // Clock one edge, advance the model from the inputs that were present at that edge, then compare.
  task automatic step(input string tag);
    logic [31:0] r;
    logic        v;
    @(posedge clk);
    if (flush || (!stall && !in_valid)) begin
      clear_model();
    end else if (!stall) begin
      ref_alu(alu_ctrl, sign, op_a, op_b, shamt, r, v);
      e_valid = 1; e_result = r; e_zero = (r == 0); e_ovf = v; e_rd = in_rd;
      e_rw = in_reg_write && !v;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_model();
    #1;
    chk_all("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset_hold");
    reset = 1'b0;

    drive(5'd0, 1, 32'h7FFFFFFF, 32'h1, 0, 5'd3, 1, 1, 0, 0); step("add_s");
    chk("add_s_res", out_result, 32'h80000000);
    chk("add_s_ovf", 32'(out_ovf), 32'd1);
    chk("add_s_rw",  32'(out_reg_write), 32'd0);
    chk("add_s_vld", 32'(out_valid), 32'd1);
    drive(5'd0, 0, 32'h7FFFFFFF, 32'h1, 0, 5'd3, 1, 1, 0, 0); step("add_u");
    chk("add_u_ovf", 32'(out_ovf), 32'd0);
    chk("add_u_rw",  32'(out_reg_write), 32'd1);

    drive(5'd9, 1, 32'hFFFFFFFF, 32'h1, 0, 5'd4, 1, 1, 0, 0); step("slt_s");
    chk("slt_s_res", out_result, 32'd1);
    drive(5'd9, 0, 32'hFFFFFFFF, 32'h1, 0, 5'd4, 1, 1, 0, 0); step("slt_u");
    chk("slt_u_res", out_result, 32'd0);
    chk("slt_u_zero", 32'(out_zero), 32'd1);

    drive(5'd6, 0, 0, 32'h80000010, 5'd4, 5'd5, 1, 1, 0, 0); step("sll");
    chk("sll_res", out_result, 32'h00000100);
    drive(5'd7, 0, 0, 32'h80000010, 5'd4, 5'd5, 1, 1, 0, 0); step("srl");
    chk("srl_res", out_result, 32'h08000001);
    drive(5'd8, 0, 0, 32'h80000010, 5'd4, 5'd5, 1, 1, 0, 0); step("sra");
    chk("sra_res", out_result, 32'hF8000001);
    drive(5'd8, 0, 0, 32'h80000010, 5'd0, 5'd5, 1, 1, 0, 0); step("sra0");
    chk("sra0_res", out_result, 32'h80000010);

    drive(5'd1, 1, 32'h1234, 32'h1234, 0, 5'd6, 0, 1, 0, 0); step("beq");
    chk("beq_res", out_result, 32'd0);
    chk("beq_zero", 32'(out_zero), 32'd1);
    chk("beq_ovf", 32'(out_ovf), 32'd0);

    drive(5'd0, 1, 32'd3, 32'd4, 0, 5'd7, 1, 1, 0, 0); step("add34");
    chk("add34_res", out_result, 32'd7);
    drive(5'd2, 0, 32'hFF, 32'h0F, 0, 5'd8, 1, 1, 1, 0); step("stall1");
    drive(5'd3, 0, 32'hF0, 32'h0F, 0, 5'd9, 1, 1, 1, 0); step("stall2");
    chk("stall2_res", out_result, 32'd7);
    drive(5'd3, 0, 32'hF0, 32'h0F, 0, 5'd9, 1, 1, 1, 1); step("stall_flush");
    chk("sf_vld", 32'(out_valid), 32'd0);
    chk("sf_res", out_result, 32'd0);

    drive(5'd20, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 5'd1, 1, 1, 0, 0); step("code20");
    drive(5'd1, 1, 32'h80000000, 32'h1, 0, 5'd2, 1, 1, 0, 0); step("sub_ovf");
    drive(5'd4, 0, 32'hAAAA5555, 32'hFFFF0000, 0, 5'd2, 1, 0, 0, 0); step("bubble");

    // Asynchronous reset between edges while a valid slot is held.
    drive(5'd0, 0, 32'd10, 32'd20, 0, 5'd11, 1, 1, 0, 0); step("pre_rst");
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    stall = 1'b1;
    reset = 1'b1;
    #1;
    clear_model();
    chk_all("async_rst");
    #1;
    reset = 1'b0;
    drive(5'd0, 0, 32'd5, 32'd6, 0, 5'd12, 1, 1, 0, 0); step("post_rst");
    chk("post_rst_res", out_result, 32'd11);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      logic [4:0]  op;
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'h7FFFFFFF;
      if ($urandom_range(0, 9) == 0) b = a;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
      drive(op, 1'($urandom), a, b, 5'($urandom), 5'($urandom), 1'($urandom),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined MIPS CPU; directly downstream of the ALU control decoder.
- Consumes the decoded 5-bit ALU operation and Sign flag with the ID/EX operands, computes the result, zero and overflow flags, and registers them into the EX/MEM pipeline register.
- Supports stall (hold), flush (bubble insert) and signed-overflow write suppression.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  ID/EX slot holds a real instruction
- alu_ctrl  in  5  op code: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLL=6, SRL=7, SRA=8, SLT=9
- sign  in  1  1 = signed (overflow check, signed SLT); 0 = unsigned
- op_a  in  DATA_W  operand A (rs value)
- op_b  in  DATA_W  operand B (rt value or extended immediate)
- shamt  in  5  shift amount
- in_rd  in  REG_AW  destination register
- in_reg_write  in  1  instruction writes the register file
- stall  in  1  hold EX/MEM contents
- flush  in  1  load a bubble into EX/MEM
- out_valid  out  1  EX/MEM slot valid
- out_result  out  DATA_W  registered ALU result
- out_zero  out  1  registered (result == 0)
- out_ovf  out  1  registered signed-overflow flag
- out_rd  out  REG_AW  registered destination
- out_reg_write  out  1  registered write enable, overflow-suppressed

Behaviour:
- Reset (async assert, clk-sync release): all outputs 0.
- Latency: combinational compute, outputs registered; one cycle from inputs to outputs.
- Per rising edge, priority is reset > flush > stall > load.
- flush: out_valid=0, out_reg_write=0, out_ovf=0; out_result, out_zero and out_rd are cleared to 0.
- stall without flush: all outputs hold their values.
- load: outputs take the computed values. When in_valid=0, the slot loads as a bubble with the same values as flush.
- ADD/SUB: modulo 2^DATA_W wrap. Overflow applies only when sign=1:
  - ADD overflows when operand signs match and the result sign differs.
  - SUB overflows when operand signs differ and the result sign differs from op_a.
- sign=0 never raises overflow.
- AND/OR/XOR/NOR: bitwise on op_a, op_b.
- Shifts:
  - SLL = op_b << shamt.
  - SRL = op_b >> shamt, zero fill.
  - SRA = op_b >>> shamt, sign fill.
  - shamt=0 passes op_b unchanged.
- SLT: result is 1 or 0. Compare is signed when sign=1, unsigned when sign=0.
- Codes 10–31: result 0, no overflow.
- out_zero reflects the final result; the branch unit uses it for beq, which uses SUB.
- Overflow suppression: out_ovf=1 forces out_reg_write=0 that cycle. out_valid stays 1 so the exception path can see the event.
- out_ovf is a one-slot flag, not sticky. It is held only while stalled.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stall: outputs clear immediately, with no dependence on clk.

Decomposition:
- Shared package alu_pkg: ALU op-code localparams (ADD..SLT, 5-bit), DATA_W, REG_AW defaults. The control decoder and this block both import it.
- One sub-module, alu_core: purely combinational. It takes alu_ctrl, sign, op_a, op_b, shamt and returns result, zero, ovf.
- ex_stage holds only the EX/MEM register and the stall/flush/valid control.

Test Plan:
- ADD signed overflow: sign=1, op_a=0x7FFFFFFF, op_b=1, in_reg_write=1 → next cycle out_result=0x80000000, out_ovf=1, out_reg_write=0, out_valid=1. The same with sign=0 → out_ovf=0, out_reg_write=1.
- SLT signedness: op_a=0xFFFFFFFF, op_b=1 → sign=1 gives out_result=1; sign=0 gives out_result=0, out_zero=1.
- Shifts on op_b=0x80000010, shamt=4:
  - SLL → 0x00000100
  - SRL → 0x08000001
  - SRA → 0xF8000001
  - shamt=0 → 0x80000010
- SUB/zero for beq: op_a=op_b=0x1234 → out_result=0, out_zero=1, out_ovf=0.
- Stall/flush priority:
  - Load ADD 3+4 (out_result=7), then stall=1 for 2 cycles with new inputs → outputs hold 7.
  - Stall and flush together → out_valid=0, out_reg_write=0, out_result=0.
- Reset mid-operation: assert reset between edges while out_valid=1 → all outputs 0 immediately. After release, the first edge with in_valid=1 loads normally.
